ptw_sv39: RTL and testbench
===========================

// Module: ptw_sv39
// PURPOSE
//  Sv39 page-table walker: responder end of the TLB->PTW miss interface. Accepts one TLB miss
//  (VPN + store/fetch), walks up to 3 levels through a single-outstanding memory port, sets the
//  leaf A/D bits in memory when needed, and returns the leaf PTE, its level and an error flag.
//  It also forwards sfence/satp flushes to the TLB as invalidate_tlb, plus the SUM/MXR status.
// PARAMETERS
//  PPN_WIDTH  44  physical page number width; physical address = PPN_WIDTH+12 bits
//  VPN_WIDTH  27  Sv39 VPN width, 3 x 9-bit indexes
//  PTE_WIDTH  64  page-table entry width; memory data width
// PORTS
//  clk_i             in   1          clock
//  rstn_i            in   1          asynchronous active-low reset
//  req_valid_i       in   1          TLB miss request valid
//  req_vpn_i         in   VPN_WIDTH  VPN to translate
//  req_store_i       in   1          miss caused by a store (D bit needed)
//  req_fetch_i       in   1          miss caused by a fetch (informational, registered)
//  ptw_ready_o       out  1          request accepted when req_valid_i & ptw_ready_o
//  resp_valid_o      out  1          one-cycle response pulse
//  resp_error_o      out  1          page fault / memory error / walk killed by flush
//  resp_pte_o        out  PTE_WIDTH  final PTE (leaf PTE with updated A/D, else last PTE read, else 0)
//  resp_level_o      out  2          mmu_pkg encoding: GIGA_PAGE, MEGA_PAGE, KILO_PAGE
//  invalidate_tlb_o  out  1          = flush_i (combinational)
//  status_sum_o      out  1          = csr_sum_i;  status_mxr_o out 1 = csr_mxr_i
//  satp_ppn_i        in   PPN_WIDTH  root page-table PPN
//  flush_i           in   1          sfence.vma / satp write
//  csr_sum_i         in   1          mstatus.SUM;  csr_mxr_i in 1 = mstatus.MXR
//  mem_req_valid_o   out  1          memory request; addr/we/wdata held stable until ready
//  mem_req_ready_i   in   1          memory accepts request this cycle
//  mem_req_we_o      out  1          1 = PTE write-back (A/D update), 0 = PTE read
//  mem_req_addr_o    out  PPN_WIDTH+12  PTE byte address, 8-byte aligned
//  mem_req_wdata_o   out  PTE_WIDTH  write data
//  mem_resp_valid_i  in   1          read data / write ack (exactly one per accepted request)
//  mem_resp_data_i   in   PTE_WIDTH  read data
//  mem_resp_err_i    in   1          bus error, qualified by mem_resp_valid_i
// BEHAVIOUR
//  Reset: state IDLE, all registers 0; ptw_ready_o=1, every other registered output 0.
//  States: IDLE, MEM_REQ, WAIT_MEM, WB_REQ, WAIT_WB, RESP. ptw_ready_o=1 only in IDLE.
//  IDLE: on accept latch vpn/store/fetch, base=satp_ppn_i, level=GIGA; ->MEM_REQ (->RESP, killed, if flush_i same cycle).
//  MEM_REQ: addr = {base,12'b0} + vpn[level idx]*8 (idx bits [26:18],[17:9],[8:0]); ready -> WAIT_MEM.
//  WAIT_MEM on resp: err -> error, RESP. V=0 or (!R & W) -> error, RESP.
//   Non-leaf (R=X=0): at KILO -> error, RESP; else base=pte.ppn, level down one, ->MEM_REQ.
//   Leaf: misaligned superpage (GIGA: ppn[17:0]!=0, MEGA: ppn[8:0]!=0) -> error, RESP.
//   Leaf needing update (A=0, or store & W & D=0): pte.A=1, pte.D|=store&W -> WB_REQ (we=1, same addr).
//   Otherwise RESP with the leaf PTE.
//  WB_REQ -> WAIT_WB on ready; WAIT_WB on resp -> RESP (err -> error=1); resp_pte_o = updated PTE.
//  RESP: resp_valid_o=1 exactly one cycle, -> IDLE (ready next cycle; no back-to-back accept).
//  Flush: flush_i in any non-IDLE state sets killed; MEM_REQ/WB_REQ not yet accepted -> RESP;
//   WAIT_MEM/WAIT_WB wait for mem_resp_valid_i then -> RESP. Killed response: error=1, no write-back.
//  Every accepted request gets exactly one resp_valid_o; memory never has >1 outstanding.
//  Reset mid-walk: immediate return to IDLE; outstanding memory response afterwards is ignored.
// TESTING
//  satp=0x100, vpn=0x0_0401, 3 valid pointer/leaf PTEs, A=D=1 -> reads 0x100000,+0x?; resp level KILO, error 0.
//  Level-2 PTE R=1 ppn=0x40000 (aligned) -> one read, resp level GIGA; ppn=0x40001 -> error=1.
//  Store miss, leaf W=1 A=1 D=0 -> read then write at same addr with D=1; resp_pte_o.D=1.
//  Level-1 PTE V=0 -> error=1 after 2 reads; mem_resp_err_i on read 1 -> error=1, no further reads.
//  flush_i during WAIT_MEM -> invalidate_tlb_o=1 same cycle, walk stops after response, error=1.
//  mem_req_ready_i low 5 cycles -> addr/we stable, ptw_ready_o=0 throughout, single response.

Source files
------------

// File: rtl/ptw_sv39.sv
// Sv39 page-table walker: serves one TLB miss at a time, walks up to three levels through a
// single-outstanding memory port, writes back A/D bits when the leaf needs them, and returns
// the leaf PTE with its level and an error flag. Also forwards flush and SUM/MXR to the TLB.
module ptw_sv39 #(
    parameter int unsigned PPN_WIDTH = 44,
    parameter int unsigned VPN_WIDTH = 27,
    parameter int unsigned PTE_WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    // TLB miss interface
    input  logic                    req_valid_i,
    input  logic [VPN_WIDTH-1:0]    req_vpn_i,
    input  logic                    req_store_i,
    input  logic                    req_fetch_i,
    output logic                    ptw_ready_o,
    output logic                    resp_valid_o,
    output logic                    resp_error_o,
    output logic [PTE_WIDTH-1:0]    resp_pte_o,
    output logic [1:0]              resp_level_o,
    output logic                    invalidate_tlb_o,
    output logic                    status_sum_o,
    output logic                    status_mxr_o,
    // CSR side
    input  logic [PPN_WIDTH-1:0]    satp_ppn_i,
    input  logic                    flush_i,
    input  logic                    csr_sum_i,
    input  logic                    csr_mxr_i,
    // Memory port
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic                    mem_req_we_o,
    output logic [PPN_WIDTH+11:0]   mem_req_addr_o,
    output logic [PTE_WIDTH-1:0]    mem_req_wdata_o,
    input  logic                    mem_resp_valid_i,
    input  logic [PTE_WIDTH-1:0]    mem_resp_data_i,
    input  logic                    mem_resp_err_i
);

    localparam int unsigned PA_WIDTH = PPN_WIDTH + 12;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] MEM_REQ  = 3'd1;
    localparam logic [2:0] WAIT_MEM = 3'd2;
    localparam logic [2:0] WB_REQ   = 3'd3;
    localparam logic [2:0] WAIT_WB  = 3'd4;
    localparam logic [2:0] RESP     = 3'd5;

    // Level encoding: walk starts at GIGA and counts up towards KILO.
    localparam logic [1:0] GIGA_PAGE = 2'd0;
    localparam logic [1:0] MEGA_PAGE = 2'd1;
    localparam logic [1:0] KILO_PAGE = 2'd2;

    logic [2:0]           state_q, state_d;
    logic [VPN_WIDTH-1:0] vpn_q, vpn_d;
    logic                 store_q, store_d;
    logic                 fetch_q, fetch_d;
    logic [PPN_WIDTH-1:0] base_q, base_d;
    logic [1:0]           level_q, level_d;
    logic [PTE_WIDTH-1:0] pte_q, pte_d;
    logic                 error_q, error_d;
    logic                 killed_q, killed_d;

    logic [8:0]           vpn_idx;
    logic                 rd_v, rd_r, rd_w, rd_x, rd_a, rd_d;
    logic [PPN_WIDTH-1:0] rd_ppn;
    logic                 rd_misaligned;

    // Fetch flag is kept for the TLB side but does not affect the walk.
    logic unused_fetch;
    assign unused_fetch = fetch_q;

    // Fields of the PTE arriving on the memory response.
    assign rd_v   = mem_resp_data_i[0];
    assign rd_r   = mem_resp_data_i[1];
    assign rd_w   = mem_resp_data_i[2];
    assign rd_x   = mem_resp_data_i[3];
    assign rd_a   = mem_resp_data_i[6];
    assign rd_d   = mem_resp_data_i[7];
    assign rd_ppn = mem_resp_data_i[PPN_WIDTH+9:10];

    // Select the 9-bit VPN slice for the current level.
    always_comb begin
        unique case (level_q)
            GIGA_PAGE: vpn_idx = vpn_q[26:18];
            MEGA_PAGE: vpn_idx = vpn_q[17:9];
            default:   vpn_idx = vpn_q[8:0];
        endcase
    end

    // Superpage leaves must have their low PPN bits clear.
    always_comb begin
        unique case (level_q)
            GIGA_PAGE: rd_misaligned = (rd_ppn[17:0] != '0);
            MEGA_PAGE: rd_misaligned = (rd_ppn[8:0] != '0);
            default:   rd_misaligned = 1'b0;
        endcase
    end

    assign mem_req_addr_o  = {base_q, 12'b0} + {{(PA_WIDTH-12){1'b0}}, vpn_idx, 3'b000};
    assign mem_req_valid_o = (state_q == MEM_REQ) || (state_q == WB_REQ);
    assign mem_req_we_o    = (state_q == WB_REQ);
    assign mem_req_wdata_o = pte_q;

    assign ptw_ready_o      = (state_q == IDLE);
    assign resp_valid_o     = (state_q == RESP);
    assign resp_error_o     = error_q;
    assign resp_pte_o       = pte_q;
    assign resp_level_o     = level_q;
    assign invalidate_tlb_o = flush_i;
    assign status_sum_o     = csr_sum_i;
    assign status_mxr_o     = csr_mxr_i;

    // Walk sequencing and next-state computation.
    always_comb begin
        state_d  = state_q;
        vpn_d    = vpn_q;
        store_d  = store_q;
        fetch_d  = fetch_q;
        base_d   = base_q;
        level_d  = level_q;
        pte_d    = pte_q;
        error_d  = error_q;
        killed_d = killed_q;

        if ((state_q != IDLE) && flush_i) begin
            killed_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    vpn_d    = req_vpn_i;
                    store_d  = req_store_i;
                    fetch_d  = req_fetch_i;
                    base_d   = satp_ppn_i;
                    level_d  = GIGA_PAGE;
                    pte_d    = '0;
                    error_d  = 1'b0;
                    killed_d = 1'b0;
                    if (flush_i) begin
                        killed_d = 1'b1;
                        error_d  = 1'b1;
                        state_d  = RESP;
                    end else begin
                        state_d = MEM_REQ;
                    end
                end
            end
            MEM_REQ, WB_REQ: begin
                // Once accepted the response must be absorbed even if a flush arrives.
                if (mem_req_ready_i) begin
                    state_d = (state_q == MEM_REQ) ? WAIT_MEM : WAIT_WB;
                end else if (flush_i) begin
                    error_d = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT_MEM: begin
                if (mem_resp_valid_i) begin
                    state_d = RESP;
                    if (mem_resp_err_i) begin
                        error_d = 1'b1;
                    end else begin
                        pte_d = mem_resp_data_i;
                        if (killed_q || flush_i) begin
                            error_d = 1'b1;
                        end else if (!rd_v || (!rd_r && rd_w)) begin
                            error_d = 1'b1;
                        end else if (!rd_r && !rd_x) begin
                            if (level_q == KILO_PAGE) begin
                                error_d = 1'b1;
                            end else begin
                                base_d  = rd_ppn;
                                level_d = level_q + 2'd1;
                                state_d = MEM_REQ;
                            end
                        end else if (rd_misaligned) begin
                            error_d = 1'b1;
                        end else if (!rd_a || (store_q && rd_w && !rd_d)) begin
                            pte_d[6] = 1'b1;
                            pte_d[7] = rd_d | (store_q & rd_w);
                            state_d  = WB_REQ;
                        end
                    end
                end
            end
            WAIT_WB: begin
                if (mem_resp_valid_i) begin
                    state_d = RESP;
                    if (mem_resp_err_i || killed_q || flush_i) begin
                        error_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any walk in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            vpn_q    <= '0;
            store_q  <= 1'b0;
            fetch_q  <= 1'b0;
            base_q   <= '0;
            level_q  <= GIGA_PAGE;
            pte_q    <= '0;
            error_q  <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vpn_q    <= vpn_d;
            store_q  <= store_d;
            fetch_q  <= fetch_d;
            base_q   <= base_d;
            level_q  <= level_d;
            pte_q    <= pte_d;
            error_q  <= error_d;
            killed_q <= killed_d;
        end
    end

endmodule

// File: tb/tb_ptw_sv39.sv
// Directed testbench for ptw_sv39 with a small behavioural page-table memory.
module tb_ptw_sv39;

    localparam logic [1:0] LVL_GIGA = 2'd0;
    localparam logic [1:0] LVL_MEGA = 2'd1;
    localparam logic [1:0] LVL_KILO = 2'd2;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [26:0] req_vpn_i = '0;
    logic        req_store_i = 1'b0;
    logic        req_fetch_i = 1'b0;
    logic        ptw_ready_o, resp_valid_o, resp_error_o;
    logic [63:0] resp_pte_o;
    logic [1:0]  resp_level_o;
    logic        invalidate_tlb_o, status_sum_o, status_mxr_o;
    logic [43:0] satp_ppn_i = 44'h100;
    logic        flush_i = 1'b0;
    logic        csr_sum_i = 1'b0;
    logic        csr_mxr_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_req_we_o;
    logic [55:0] mem_req_addr_o;
    logic [63:0] mem_req_wdata_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [63:0] mem_resp_data_i = '0;
    logic        mem_resp_err_i = 1'b0;

    ptw_sv39 dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .req_valid_i      (req_valid_i),
        .req_vpn_i        (req_vpn_i),
        .req_store_i      (req_store_i),
        .req_fetch_i      (req_fetch_i),
        .ptw_ready_o      (ptw_ready_o),
        .resp_valid_o     (resp_valid_o),
        .resp_error_o     (resp_error_o),
        .resp_pte_o       (resp_pte_o),
        .resp_level_o     (resp_level_o),
        .invalidate_tlb_o (invalidate_tlb_o),
        .status_sum_o     (status_sum_o),
        .status_mxr_o     (status_mxr_o),
        .satp_ppn_i       (satp_ppn_i),
        .flush_i          (flush_i),
        .csr_sum_i        (csr_sum_i),
        .csr_mxr_i        (csr_mxr_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_err_i   (mem_resp_err_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural memory: decides ready and accepts requests on the falling edge.
    logic [63:0] mem [logic [55:0]];
    logic [55:0] rd_addr_q [$];
    int          stall_cnt = 0;
    int          resp_cnt = 0;
    int          resp_lat = 1;
    int          rd_count = 0;
    int          wr_count = 0;
    int          err_read_idx = -1;
    int          resp_pulses = 0;
    logic [55:0] last_wr_addr = '0;
    logic [63:0] last_wr_data = '0;
    logic [63:0] pend_data = '0;
    logic        pend_err = 1'b0;

    always @(negedge clk_i) begin
        mem_resp_valid_i = 1'b0;
        mem_resp_err_i   = 1'b0;
        mem_resp_data_i  = '0;
        if (resp_cnt != 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = pend_data;
                mem_resp_err_i   = pend_err;
            end
        end
        if (stall_cnt != 0) begin
            mem_req_ready_i = 1'b0;
            stall_cnt--;
        end else begin
            mem_req_ready_i = 1'b1;
        end
        if (rstn_i && mem_req_valid_o && mem_req_ready_i) begin
            if (mem_req_we_o) begin
                mem[mem_req_addr_o] = mem_req_wdata_o;
                last_wr_addr = mem_req_addr_o;
                last_wr_data = mem_req_wdata_o;
                wr_count++;
                pend_data = '0;
                pend_err  = 1'b0;
            end else begin
                rd_addr_q.push_back(mem_req_addr_o);
                pend_data = mem.exists(mem_req_addr_o) ? mem[mem_req_addr_o] : 64'h0;
                pend_err  = (rd_count == err_read_idx);
                rd_count++;
            end
            resp_cnt = resp_lat;
        end
    end

    always @(negedge clk_i) begin
        if (resp_valid_o) resp_pulses++;
    end

    function automatic logic [55:0] rd_addr_at(input int i);
        return (i < rd_addr_q.size()) ? rd_addr_q[i] : 56'hFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic reset_mem();
        mem.delete();
        rd_addr_q.delete();
        rd_count     = 0;
        wr_count     = 0;
        err_read_idx = -1;
        resp_lat     = 1;
        stall_cnt    = 0;
    endtask

    // Three-level chain for vpn 0x401: idx2=0, idx1=2, idx0=1.
    task automatic load_chain(input logic [63:0] leaf);
        mem[56'h100000] = 64'h80001;  // pointer to ppn 0x200
        mem[56'h200010] = 64'hC0001;  // pointer to ppn 0x300
        mem[56'h300008] = leaf;
    endtask

    int p0;

    task automatic start_walk(input logic [26:0] vpn, input logic st);
        p0 = resp_pulses;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_vpn_i   = vpn;
        req_store_i = st;
        req_fetch_i = ~st;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic finish_walk(input string nm, input logic exp_err, input logic [63:0] exp_pte,
                               input logic [1:0] exp_lvl, input int exp_rd, input int exp_wr);
        logic got = 1'b0;
        logic err = 1'b0;
        logic rdy = 1'b1;
        logic [63:0] pte = '0;
        logic [1:0] lvl = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk_i);
            if (resp_valid_o) begin
                got = 1'b1;
                err = resp_error_o;
                pte = resp_pte_o;
                lvl = resp_level_o;
                rdy = ptw_ready_o;
            end
        end
        repeat (3) @(negedge clk_i);
        check_eq({nm, ".resp_seen"}, 64'(got), 64'd1);
        check_eq({nm, ".error"}, 64'(err), 64'(exp_err));
        check_eq({nm, ".pte"}, pte, exp_pte);
        check_eq({nm, ".level"}, 64'(lvl), 64'(exp_lvl));
        check_eq({nm, ".ready_in_resp"}, 64'(rdy), 64'd0);
        check_eq({nm, ".reads"}, 64'(rd_count), 64'(exp_rd));
        check_eq({nm, ".writes"}, 64'(wr_count), 64'(exp_wr));
        check_eq({nm, ".resp_pulses"}, 64'(resp_pulses - p0), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check_eq("rst.ready", 64'(ptw_ready_o), 64'd1);
        check_eq("rst.resp_valid", 64'(resp_valid_o), 64'd0);
        check_eq("rst.mem_valid", 64'(mem_req_valid_o), 64'd0);
        check_eq("rst.error", 64'(resp_error_o), 64'd0);
        check_eq("rst.pte", resp_pte_o, 64'd0);
        check_eq("rst.level", 64'(resp_level_o), 64'd0);
        csr_sum_i = 1'b1;
        #1;
        check_eq("csr.sum", 64'(status_sum_o), 64'd1);
        check_eq("csr.mxr", 64'(status_mxr_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Full three-level walk, leaf already has A and D
        reset_mem();
        load_chain(64'h48D14CF);
        start_walk(27'h401, 1'b0);
        finish_walk("kilo", 1'b0, 64'h48D14CF, LVL_KILO, 3, 0);
        check_eq("kilo.addr0", 64'(rd_addr_at(0)), 64'h100000);
        check_eq("kilo.addr1", 64'(rd_addr_at(1)), 64'h200010);
        check_eq("kilo.addr2", 64'(rd_addr_at(2)), 64'h300008);

        // Aligned and misaligned gigapage leaves
        reset_mem();
        mem[56'h100000] = 64'h100000CF;
        start_walk(27'h401, 1'b0);
        finish_walk("giga", 1'b0, 64'h100000CF, LVL_GIGA, 1, 0);
        reset_mem();
        mem[56'h100000] = 64'h100004CF;
        start_walk(27'h401, 1'b0);
        finish_walk("giga_mis", 1'b1, 64'h100004CF, LVL_GIGA, 1, 0);

        // Store miss to a writable clean page sets D via write-back
        reset_mem();
        load_chain(64'h48D1447);
        start_walk(27'h401, 1'b1);
        finish_walk("store_d", 1'b0, 64'h48D14C7, LVL_KILO, 3, 1);
        check_eq("store_d.wr_addr", 64'(last_wr_addr), 64'h300008);
        check_eq("store_d.wr_data", last_wr_data, 64'h48D14C7);

        // Load miss to a page with A=0 sets only A
        reset_mem();
        load_chain(64'h48D1407);
        start_walk(27'h401, 1'b0);
        finish_walk("load_a", 1'b0, 64'h48D1447, LVL_KILO, 3, 1);
        check_eq("load_a.wr_data", last_wr_data, 64'h48D1447);

        // Invalid level-1 PTE
        reset_mem();
        mem[56'h100000] = 64'h80001;
        start_walk(27'h401, 1'b0);
        finish_walk("v0_l1", 1'b1, 64'h0, LVL_MEGA, 2, 0);

        // Bus error on the first read
        reset_mem();
        load_chain(64'h48D14CF);
        err_read_idx = 0;
        start_walk(27'h401, 1'b0);
        finish_walk("bus_err", 1'b1, 64'h0, LVL_GIGA, 1, 0);

        // Flush while the first read is outstanding
        reset_mem();
        load_chain(64'h48D14CF);
        resp_lat = 4;
        start_walk(27'h401, 1'b0);
        for (int i = 0; i < 50 && rd_count < 1; i++) @(negedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        #1 check_eq("flush.invalidate", 64'(invalidate_tlb_o), 64'd1);
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        finish_walk("flush", 1'b1, 64'h80001, LVL_GIGA, 1, 0);

        // Memory holds off ready for five cycles on the first read
        reset_mem();
        load_chain(64'h48D14CF);
        stall_cnt = 6;
        start_walk(27'h401, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq("stall.valid", 64'(mem_req_valid_o), 64'd1);
            check_eq("stall.addr", 64'(mem_req_addr_o), 64'h100000);
            check_eq("stall.we", 64'(mem_req_we_o), 64'd0);
            check_eq("stall.ready", 64'(ptw_ready_o), 64'd0);
        end
        finish_walk("stall", 1'b0, 64'h48D14CF, LVL_KILO, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
